// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack memory handshake,
// and presents each instruction for one issue window while computing the next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  Jmp,
  input  logic        PCSrc,
  input  logic [31:0] jr_target,
  input  logic        stall
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, instr_q, next_pc, br_off;
  logic [1:0]  jr_unused;

  assign jr_unused = jr_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = ISSUE;
      ISSUE:   if (!stall)   state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == ISSUE);
  end

  // next_pc feeds pc directly so taken jumps/branches fetch without a bubble
  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (Jmp)
      2'b00:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b10:   next_pc = {jr_target[31:2], 2'b00};
      default: if (PCSrc) next_pc = pc_plus4 + br_off;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      if (state == REQ && imem_ack)  instr_q <= imem_rdata;
      if (state == ISSUE && !stall)  pc      <= next_pc;
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign instr     = instr_q;

endmodule
